mul_iter_ctrl: RTL and testbench

MUL_ITER_CTRL -- requirements
Module: mul_iter_ctrl

---
 rtl/mul_pkg.sv | 29 ++
 rtl/Array_MUL_USign.sv | 30 +++
 rtl/mul_iter_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_mul_iter_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_pkg : shared widths, op encodings and FSM states for the      |
// |           iterative multiplier controller                          |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package mul_pkg;

    localparam int XLEN  = 32;
    localparam int CHUNK = 11;
    localparam int NITER = (XLEN + CHUNK - 1) / CHUNK;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULH   = 2'b01,
        OP_MULHSU = 2'b10,
        OP_MULHU  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PREP = 3'd1,
        ST_ITER = 3'd2,
        ST_FIX  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

endpackage
`default_nettype wire

// File: rtl/Array_MUL_USign.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Array_MUL_USign : combinational unsigned A_W x B_W array multiplier|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module Array_MUL_USign #(
    parameter int A_W = 32,
    parameter int B_W = 11
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);

    logic [A_W+B_W-1:0] w_a_ext;

    assign w_a_ext = {{B_W{1'b0}}, a};

    // One shifted row of A per set bit of B, summed down the array.
    always_comb begin
        p = '0;
        for (int i = 0; i < B_W; i++) begin
            if (b[i]) begin
                p = p + (w_a_ext << i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mul_iter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mul_iter_ctrl : RV32M multiply sequencer, CHUNK multiplier bits   |
// |                 per cycle through one shared array multiplier      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module mul_iter_ctrl import mul_pkg::*; #(
    parameter int XLEN  = mul_pkg::XLEN,
    parameter int CHUNK = mul_pkg::CHUNK
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int ITERS = (XLEN + CHUNK - 1) / CHUNK;
    localparam int KW    = (ITERS > 1) ? $clog2(ITERS) : 1;
    localparam int BEXT  = ITERS * CHUNK;
    localparam int PW    = XLEN + CHUNK;
    localparam int AW    = 2 * XLEN;
    localparam logic [KW-1:0] K_LAST = KW'(ITERS - 1);

    state_e          state_q, state_d;
    op_e             op_q, op_d;
    logic [XLEN-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
    logic [XLEN-1:0] a_mag_q, a_mag_d, b_mag_q, b_mag_d;
    logic            neg_q, neg_d;
    logic [KW-1:0]   k_q, k_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;
    logic            busy_q, busy_d;

    logic            w_sa, w_sb;
    logic [BEXT-1:0] w_b_ext;
    logic [CHUNK-1:0] w_chunk;
    logic [PW-1:0]   w_pp;
    logic [AW-1:0]   w_pp_sh;
    logic [AW-1:0]   w_acc_fix;

    assign w_sa      = rs1_q[XLEN-1] & ((op_q == OP_MULH) | (op_q == OP_MULHSU));
    assign w_sb      = rs2_q[XLEN-1] & (op_q == OP_MULH);
    assign w_b_ext   = {{(BEXT-XLEN){1'b0}}, b_mag_q};
    assign w_chunk   = w_b_ext[k_q*CHUNK +: CHUNK];
    assign w_pp_sh   = {{(AW-PW){1'b0}}, w_pp} << (k_q * CHUNK);
    assign w_acc_fix = neg_q ? -acc_q : acc_q;

    Array_MUL_USign #(
        .A_W (XLEN),
        .B_W (CHUNK)
    ) u_array_mul (
        .a (a_mag_q),
        .b (w_chunk),
        .p (w_pp)
    );

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        a_mag_d     = a_mag_q;
        b_mag_d     = b_mag_q;
        neg_d       = neg_q;
        k_d         = k_q;
        acc_d       = acc_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    op_d       = op_e'(op);
                    rs1_d      = rs1;
                    rs2_d      = rs2;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = ST_PREP;
                end
            end
            ST_PREP: begin
                a_mag_d = w_sa ? -rs1_q : rs1_q;
                b_mag_d = w_sb ? -rs2_q : rs2_q;
                neg_d   = w_sa ^ w_sb;
                acc_d   = '0;
                k_d     = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                acc_d = acc_q + w_pp_sh;
                if (k_q == K_LAST) begin
                    state_d = ST_FIX;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_FIX: begin
                result_d    = (op_q == OP_MUL) ? w_acc_fix[XLEN-1:0] : w_acc_fix[AW-1:XLEN];
                out_valid_d = 1'b1;
                state_d     = ST_DONE;
            end
            ST_DONE: begin
                if (out_ready) begin
                    result_d    = '0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d     = ST_IDLE;
                result_d    = '0;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase

        // Abort wins over every handshake in the same cycle.
        if (flush) begin
            state_d     = ST_IDLE;
            acc_d       = '0;
            k_d         = '0;
            result_d    = '0;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
            in_ready_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MUL;
            rs1_q       <= '0;
            rs2_q       <= '0;
            a_mag_q     <= '0;
            b_mag_q     <= '0;
            neg_q       <= 1'b0;
            k_q         <= '0;
            acc_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            a_mag_q     <= a_mag_d;
            b_mag_q     <= b_mag_d;
            neg_q       <= neg_d;
            k_q         <= k_d;
            acc_q       <= acc_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mul_iter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_mul_iter_ctrl : directed self-checking bench for mul_iter_ctrl |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_mul_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        flush = 1'b0;
    logic        out_ready = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] rs1 = '0;
    logic [31:0] rs2 = '0;
    logic        in_ready;
    logic        out_valid;
    logic        busy;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    // Cycles since acceptance; 0 = idle, DONE_PH = result presented.
    localparam int DONE_PH = 6;
    int          m_phase = 0;
    logic [31:0] m_res = '0;

    mul_iter_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Product via sign/zero extension to 64 bits, independent of magnitude splitting.
    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] a64, b64, p;
        a64 = (o == 2'b01 || o == 2'b10) ? {{32{a[31]}}, a} : {32'b0, a};
        b64 = (o == 2'b01) ? {{32{b[31]}}, b} : {32'b0, b};
        p   = a64 * b64;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
        end else if (flush) begin
            m_phase <= 0;
        end else if (m_phase == 0) begin
            if (in_valid) begin
                m_phase <= 1;
                m_res   <= ref_mul(op, rs1, rs2);
            end
        end else if (m_phase < DONE_PH) begin
            m_phase <= m_phase + 1;
        end else if (out_ready) begin
            m_phase <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            chk("cyc_out_valid", {31'b0, out_valid}, {31'b0, m_phase == DONE_PH});
            chk("cyc_result", result, (m_phase == DONE_PH) ? m_res : 32'h0);
            chk("cyc_in_ready", {31'b0, in_ready}, {31'b0, m_phase == 0});
            chk("cyc_busy", {31'b0, busy}, {31'b0, m_phase != 0});
        end
    end

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit keep);
        @(negedge clk);
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        @(posedge clk);
        #1;
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm, input logic [31:0] exp);
        int n;
        n = 0;
        while (n < 20 && !out_valid) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_latency"}, n, 5);
        chk({nm, "_result"}, result, exp);
    endtask

    task automatic take(input int stall);
        repeat (stall) @(negedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string nm, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        issue(o, a, b, 1'b0);
        wait_done(nm, exp);
        take(0);
    endtask

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_result", result, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        cmp_en = 1'b1;

        run("mul_neg",      2'b00, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB);
        run("mulh_minmin",  2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        run("mulhu_ones",   2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        run("mulhsu_ones",  2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run("mulh_m1x2",    2'b01, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
        run("mulhsu_min",   2'b10, 32'h80000000, 32'h80000000, 32'hC0000000);
        run("mulhu_zero",   2'b11, 32'hDEADBEEF, 32'h00000000, 32'h00000000);
        run("mul_mixed",    2'b00, 32'h12345678, 32'h9ABCDEF0, ref_mul(2'b00, 32'h12345678, 32'h9ABCDEF0));
        run("mulh_mixed",   2'b01, 32'h87654321, 32'h0FEDCBA9, ref_mul(2'b01, 32'h87654321, 32'h0FEDCBA9));

        // Backpressure with a second request waiting throughout.
        issue(2'b00, 32'd3, 32'd4, 1'b1);
        wait_done("bp_first", 32'd12);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_hold_result", result, 32'd12);
            chk("bp_hold_in_ready", {31'b0, in_ready}, 32'h0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("bp_idle_after_hs", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_second_accept", {31'b0, busy}, 32'h1);
        wait_done("bp_second", 32'd12);
        take(0);

        // Asynchronous reset while ITER k=1 is in progress.
        issue(2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("rstabort_busy_before", {31'b0, busy}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rstabort_busy", {31'b0, busy}, 32'h0);
        chk("rstabort_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rstabort_out_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rstabort_no_result", {31'b0, out_valid}, 32'h0);
        end
        run("after_rst", 2'b11, 32'd3, 32'd5, 32'h00000000);

        // Flush while the result is being fixed up.
        issue(2'b00, 32'd7, 32'hFFFFFFFD, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_busy", {31'b0, busy}, 32'h0);
        chk("flush_out_valid", {31'b0, out_valid}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("flush_no_result", {31'b0, out_valid}, 32'h0);
        end
        run("after_flush", 2'b11, 32'd3, 32'd5, 32'h00000000);

        // Flush in IDLE beats a simultaneous request.
        @(negedge clk);
        flush    = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_idle_no_accept", {31'b0, busy}, 32'h0);

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
